// File: rtl/press_decoder.sv
// press_decoder: classifies a debounced button into tap, double tap
// and long press, using a tick prescaler and a per-state tick counter.
module press_decoder #(
  parameter int TICK_DIV     = 100_000,
  parameter int LONG_TICKS   = 1000,
  parameter int DOUBLE_TICKS = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic tap,
  output logic double_tap,
  output logic long_press,
  output logic held
);

  localparam int TMAX =
    (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int PW = $clog2(TICK_DIV - 1) + 1;
  localparam int CW = $clog2(TMAX) + 1;
  localparam int DL = (DOUBLE_TICKS > 0) ? DOUBLE_TICKS - 1 : 0;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TMAX);
  localparam logic [CW-1:0] L_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DL);
  localparam bit            DBL_EN = (DOUBLE_TICKS > 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_SECOND,
    SECOND_PRESSED,
    LONG_HELD
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic          tick;
  logic          hit_long;
  logic          hit_dbl;
  logic          tap_d;
  logic          dtap_d;
  logic          long_d;
  logic          held_d;

  assign tick     = (presc_q == P_LAST);
  assign hit_long = tick && (cnt_q == L_LAST);
  assign hit_dbl  = tick && (cnt_q == D_LAST);

  // State and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tap        <= 1'b0;
      double_tap <= 1'b0;
      long_press <= 1'b0;
      held       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap        <= tap_d;
      double_tap <= dtap_d;
      long_press <= long_d;
      held       <= held_d;
    end
  end

  // Prescaler and saturating tick counter, both restart on any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (state_d != state_q) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick && (cnt_q != C_MAX))
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // A press only counts once the button has been seen released in IDLE.
  always_ff @(posedge clk) begin
    if (reset)
      armed_q <= 1'b0;
    else if ((state_q == IDLE) && !btn)
      armed_q <= 1'b1;
  end

  // Next state and next output values.
  always_comb begin
    state_d = state_q;
    tap_d   = 1'b0;
    dtap_d  = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn && armed_q)
          state_d = PRESSED;
      end
      PRESSED: begin
        if (!btn) begin
          if (DBL_EN) begin
            state_d = WAIT_SECOND;
          end else begin
            state_d = IDLE;
            tap_d   = 1'b1;
          end
        end else if (hit_long) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (btn) begin
          state_d = SECOND_PRESSED;
        end else if (hit_dbl) begin
          state_d = IDLE;
          tap_d   = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (!btn) begin
          state_d = IDLE;
          dtap_d  = 1'b1;
        end else if (hit_long) begin
          state_d = LONG_HELD;
          tap_d   = 1'b1;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    held_d = (state_d == LONG_HELD);
  end

endmodule
